// File: rtl/npn_pkg.sv
// Shared types and helpers for the NPN truth-table sweeper.
package npn_pkg;

  localparam int NVARS = 4;
  localparam int TT_W  = 16;
  localparam logic [7:0] PERM_ID = 8'hE4;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  // A perm is valid only when the four selectors hit every input exactly once.
  function automatic logic perm_is_valid(input logic [7:0] perm);
    logic [NVARS-1:0] seen;
    seen = '0;
    for (int i = 0; i < NVARS; i++) seen[perm[2*i +: 2]] = 1'b1;
    return &seen;
  endfunction

endpackage

// File: rtl/npn_xform.sv
// Combinational NPN input transform: minterm -> evaluator x drive.
module npn_xform
  import npn_pkg::*;
(
  input  logic [3:0] minterm,
  input  logic [3:0] neg,
  input  logic [7:0] perm,
  output logic [3:0] x
);

  always_comb begin
    x = '0;
    for (int i = 0; i < NVARS; i++) x[i] = minterm[perm[2*i +: 2]] ^ neg[i];
  end

endmodule

// File: rtl/npn_tt_sweeper.sv
// Sweeps a shared 4-input evaluator through all minterms under an NPN transform
// and returns the collected 16-bit truth table.
module npn_tt_sweeper
  import npn_pkg::*;
#(
  parameter int EVAL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_neg,
  input  logic [7:0]  req_perm,
  input  logic        req_oneg,
  output logic [3:0]  eval_x,
  input  logic        eval_y,
  output logic        tt_valid,
  input  logic        tt_ready,
  output logic [15:0] tt,
  output logic        perm_err,
  output logic        busy
);

  state_t     state, state_nxt;
  logic [3:0] neg_q;
  logic [7:0] perm_q;
  logic       oneg_q;
  logic [3:0] issue_cnt, smp_cnt;
  logic       acc, is_sweep, cap;
  logic [3:0] xf_m, xf_neg, xf_x;
  logic [7:0] xf_perm;

  assign acc       = req_valid & req_ready;
  assign is_sweep  = (state == SWEEP);
  assign req_ready = (state == IDLE);
  assign tt_valid  = (state == DONE);
  assign busy      = (state != IDLE);

  // In IDLE the transform sees the live request so T(0) is on eval_x for SWEEP cycle 0.
  always_comb begin
    xf_m    = issue_cnt + 4'd1;
    xf_neg  = neg_q;
    xf_perm = perm_q;
    if (state == IDLE) begin
      xf_m    = 4'd0;
      xf_neg  = req_neg;
      xf_perm = req_perm;
    end
  end

  npn_xform u_xform (
    .minterm (xf_m),
    .neg     (xf_neg),
    .perm    (xf_perm),
    .x       (xf_x)
  );

  // cap marks the cycle in which eval_y belongs to an issued minterm.
  if (EVAL_LAT == 0) begin : g_lat0
    assign cap = is_sweep;
  end else begin : g_pipe
    logic [EVAL_LAT-1:0] vld_pipe;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_pipe <= '0;
      else begin
        vld_pipe[0] <= is_sweep;
        for (int j = 1; j < EVAL_LAT; j++) vld_pipe[j] <= vld_pipe[j-1];
      end
    end
    assign cap = vld_pipe[EVAL_LAT-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = SWEEP;
      SWEEP:   if (issue_cnt == 4'd15) state_nxt = (EVAL_LAT == 0) ? DONE : DRAIN;
      DRAIN:   if (cap && smp_cnt == 4'd15) state_nxt = DONE;
      DONE:    if (tt_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q     <= '0;
      perm_q    <= PERM_ID;
      oneg_q    <= 1'b0;
      issue_cnt <= '0;
      smp_cnt   <= '0;
      eval_x    <= '0;
      tt        <= '0;
      perm_err  <= 1'b0;
    end else begin
      if (acc) begin
        neg_q     <= req_neg;
        perm_q    <= req_perm;
        oneg_q    <= req_oneg;
        perm_err  <= ~perm_is_valid(req_perm);
        issue_cnt <= '0;
        smp_cnt   <= '0;
        eval_x    <= xf_x;
      end
      if (is_sweep) begin
        issue_cnt <= issue_cnt + 4'd1;
        if (issue_cnt != 4'd15) eval_x <= xf_x;
      end
      // LSB-first shift: after 16 captures minterm m sits at tt[m].
      if (cap) begin
        tt      <= {eval_y ^ oneg_q, tt[15:1]};
        smp_cnt <= smp_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_npn_tt_sweeper.sv
// Directed bench for npn_tt_sweeper: one EVAL_LAT=0 and one EVAL_LAT=2 instance.
module tb_npn_tt_sweeper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        fsel = 1'b0;
  logic        req_valid = 1'b0, tt_ready = 1'b0, req_oneg = 1'b0;
  logic [3:0]  req_neg = '0;
  logic [7:0]  req_perm = 8'hE4;

  logic        rdy0, rdy2, tv0, tv2, pe0, pe2, bz0, bz2, y0, y2a, y2b;
  logic [3:0]  x0, x2;
  logic [15:0] tt0, tt2;

  logic        o_rdy, o_tv, o_pe, o_bz;
  logic [3:0]  o_x;
  logic [15:0] o_tt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // fsel 0: AND4, fsel 1: x0 & ~x1
  function automatic logic f_eval(input logic [3:0] x, input logic fs);
    return fs ? (x[0] & ~x[1]) : (&x);
  endfunction

  assign y0 = f_eval(x0, fsel);
  always @(posedge clk) begin
    y2a <= f_eval(x2, fsel);
    y2b <= y2a;
  end

  npn_tt_sweeper #(.EVAL_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rdy0),
    .req_neg(req_neg), .req_perm(req_perm), .req_oneg(req_oneg),
    .eval_x(x0), .eval_y(y0), .tt_valid(tv0), .tt_ready(tt_ready & ~sel),
    .tt(tt0), .perm_err(pe0), .busy(bz0)
  );

  npn_tt_sweeper #(.EVAL_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rdy2),
    .req_neg(req_neg), .req_perm(req_perm), .req_oneg(req_oneg),
    .eval_x(x2), .eval_y(y2b), .tt_valid(tv2), .tt_ready(tt_ready & sel),
    .tt(tt2), .perm_err(pe2), .busy(bz2)
  );

  assign o_rdy = sel ? rdy2 : rdy0;
  assign o_tv  = sel ? tv2  : tv0;
  assign o_pe  = sel ? pe2  : pe0;
  assign o_bz  = sel ? bz2  : bz0;
  assign o_x   = sel ? x2   : x0;
  assign o_tt  = sel ? tt2  : tt0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_rdy"}, 32'(o_rdy), 32'd1);
    chk({tag, "_x"},   32'(o_x),   32'd0);
    chk({tag, "_tv"},  32'(o_tv),  32'd0);
    chk({tag, "_tt"},  32'(o_tt),  32'd0);
    chk({tag, "_pe"},  32'(o_pe),  32'd0);
    chk({tag, "_bz"},  32'(o_bz),  32'd0);
  endtask

  task automatic issue(input logic [3:0] neg, input logic [7:0] perm, input logic oneg);
    req_neg = neg; req_perm = perm; req_oneg = oneg; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Runs one request to DONE; checks latency, eval_x at cycles 5 and 15+lat, result.
  task automatic sweep(input string tag, input logic [3:0] neg, input logic [7:0] perm,
                       input logic oneg, input int lat, input logic [15:0] exp_tt,
                       input logic exp_err, input logic [3:0] x5, input logic [3:0] x15,
                       input logic ack);
    int n;
    chk({tag, "_rdy0"}, 32'(o_rdy), 32'd1);
    issue(neg, perm, oneg);
    n = 0;
    while (!o_tv && n < 100) begin
      if (n == 5) begin
        chk({tag, "_x5"}, 32'(o_x), 32'(x5));
        chk({tag, "_busy"}, 32'(o_bz), 32'd1);
      end
      if (n == 15 + lat) chk({tag, "_xlast"}, 32'(o_x), 32'(x15));
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(16 + lat));
    chk({tag, "_tt"}, 32'(o_tt), 32'(exp_tt));
    chk({tag, "_perr"}, 32'(o_pe), 32'(exp_err));
    chk({tag, "_rdyD"}, 32'(o_rdy), 32'd0);
    if (ack) begin
      tt_ready = 1'b1;
      @(posedge clk); #1;
      tt_ready = 1'b0;
      chk({tag, "_tv_clr"}, 32'(o_tv), 32'd0);
      chk({tag, "_rdy_back"}, 32'(o_rdy), 32'd1);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0; #1; chk_rst("rst0");
    sel = 1'b1; #1; chk_rst("rst2");
    sel = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // AND4, identity / input negation / output negation
    fsel = 1'b0;
    sweep("and_id",   4'h0, 8'hE4, 1'b0, 0, 16'h8000, 1'b0, 4'h5, 4'hF, 1'b1);
    sweep("and_neg",  4'hF, 8'hE4, 1'b0, 0, 16'h0001, 1'b0, 4'hA, 4'h0, 1'b1);
    sweep("and_oneg", 4'h0, 8'hE4, 1'b1, 0, 16'h7FFF, 1'b0, 4'h5, 4'hF, 1'b1);

    // x0 & ~x1: identity, swap x0/x1
    fsel = 1'b1;
    sweep("f_id",   4'h0, 8'hE4, 1'b0, 0, 16'h2222, 1'b0, 4'h5, 4'hF, 1'b1);
    sweep("f_swap", 4'h0, 8'hE1, 1'b0, 0, 16'h4444, 1'b0, 4'h6, 4'hF, 1'b1);

    // duplicate selector: x0=x1=m0, AND4 -> m0&m2&m3 -> minterms 13,15
    fsel = 1'b0;
    sweep("dup", 4'h0, 8'hE0, 1'b0, 0, 16'hA000, 1'b1, 4'h7, 4'hF, 1'b0);

    // DONE backpressure: stable outputs, requests ignored, handshake not overlapped
    for (int c = 0; c < 10; c++) begin
      req_valid = c[0];
      req_perm  = 8'hE4;
      @(posedge clk); #1;
      chk("bp_tv", 32'(o_tv), 32'd1);
      chk("bp_tt", 32'(o_tt), 32'hA000);
    end
    chk("bp_rdy", 32'(o_rdy), 32'd0);
    chk("bp_pe", 32'(o_pe), 32'd1);
    req_valid = 1'b1;
    tt_ready  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    tt_ready  = 1'b0;
    chk("bp_rdy1", 32'(o_rdy), 32'd1);
    chk("bp_idle", 32'(o_bz), 32'd0);
    chk("bp_tv0", 32'(o_tv), 32'd0);
    chk("bp_hold", 32'(o_tt), 32'hA000);

    // async reset during SWEEP cycle 7
    issue(4'h3, 8'hE0, 1'b1);
    repeat (7) @(posedge clk);
    #2;
    chk("mid_busy", 32'(o_bz), 32'd1);
    rst = 1'b1;
    #1;
    chk_rst("mid_rst");
    @(posedge clk); #1;
    chk_rst("mid_rst_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    sweep("post_rst", 4'h0, 8'hE4, 1'b0, 0, 16'h8000, 1'b0, 4'h5, 4'hF, 1'b1);

    // EVAL_LAT=2 instance with 2-cycle registered evaluator
    sel = 1'b1; #1;
    sweep("lat2_and", 4'h0, 8'hE4, 1'b0, 2, 16'h8000, 1'b0, 4'h5, 4'hF, 1'b1);
    fsel = 1'b1;
    sweep("lat2_swap", 4'h0, 8'hE1, 1'b0, 2, 16'h4444, 1'b0, 4'h6, 4'hF, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/npn_tt_sweeper.md
Name: npn_tt_sweeper

Overview:
Sequencer that extracts the 16-bit truth table of a shared 4-input single-output combinational evaluator under a requested NPN transform: input permutation, input negation and output negation.
- Accepts one transform request at a time over a valid/ready handshake.
- Drives the evaluator's x inputs through all 16 minterms and collects the y output.
- Returns the transformed truth table over a second valid/ready handshake.
- Sits between the NPN-class test/characterisation logic and a single shared evaluator instance.

Parameters:
EVAL_LAT, 0, cycles from eval_x changing to eval_y valid for sampling; legal range 0..3.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  transform request valid
req_ready  out  1  block can accept a request
req_neg  in  4  input negation mask; bit i inverts eval_x[i]
req_perm  in  8  permutation; perm[2i+1:2i] = minterm bit routed to eval_x[i]; identity = 8'hE4
req_oneg  in  1  output negation
eval_x  out  4  registered drive to shared evaluator
eval_y  in  1  evaluator output
tt_valid  out  1  result valid
tt_ready  in  1  result consumer ready
tt  out  16  truth table; bit m = transformed function at minterm m
perm_err  out  1  req_perm was not a permutation (duplicate selector); valid with tt_valid
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, req_ready=1, eval_x=0, tt_valid=0, tt=0, perm_err=0, busy=0, all counters 0.
- Transform per minterm m (4 bits): eval_x[i] = m[perm[2i+1:2i]] ^ neg[i]. Sampled bit = eval_y ^ oneg. The sampled bit is written to tt[m].
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch neg/perm/oneg; compute perm_err (any two selectors equal); issue counter=0; sample counter=0; go to SWEEP.
- SWEEP:
  - eval_x holds T(k) during the k-th SWEEP cycle, k=0..15. The issue counter advances by one every cycle.
  - The sample for minterm k is captured at the clock edge ending cycle k+EVAL_LAT, into an LSB-first shift register (tt <= {bit, tt[15:1]}). Bit m therefore lands at tt[m].
  - After T(15) is issued: go to DRAIN if EVAL_LAT>0, otherwise go directly to DONE on the 16th capture.
- DRAIN: hold eval_x at T(15). Capture the remaining EVAL_LAT samples, then go to DONE.
- Latency: tt_valid rises exactly 16+EVAL_LAT cycles after the accepting edge.
- DONE:
  - tt_valid=1. tt and perm_err are stable.
  - req_ready=0. No request is accepted in the same cycle as the tt handshake.
  - On tt_valid&tt_ready: go to IDLE and clear tt_valid. tt keeps its value until the next capture begins.
  - tt_ready low holds DONE indefinitely.
- Request inputs are ignored outside IDLE. Config is latched, so changing req_* mid-sweep has no effect.
- perm_err does not abort the sweep. Duplicate selectors are applied literally, so some minterm bits never reach eval_x.
- eval_x only changes in SWEEP. It holds its last value in DRAIN, DONE and IDLE; it is 0 only after reset.
- rst mid-sweep or mid-DONE: immediate return to reset values. A partial tt is discarded and no tt_valid pulse occurs.
- Minimum request-to-request period: 16+EVAL_LAT+2 cycles (DONE handshake cycle, then IDLE accept).

Decomposition:
- Shared package npn_pkg:
  - state enum {IDLE, SWEEP, DRAIN, DONE}
  - NVARS=4, TT_W=16
  - PERM_ID=8'hE4
  - function perm_is_valid(perm)
- One sub-module npn_xform: purely combinational, (minterm[3:0], neg, perm) -> x[3:0]. Instantiated once to feed the eval_x register.

Test Plan:
1. Evaluator=AND4, EVAL_LAT=0, neg=0, perm=E4, oneg=0 -> tt=16'h8000, perm_err=0, tt_valid exactly 16 cycles after accept.
2. AND4, neg=4'hF, perm=E4 -> tt=16'h0001. Same request with neg=0, oneg=1 -> tt=16'h7FFF.
3. Evaluator f=x0&~x1 (identity tt=16'h2222), perm=8'hE1 (swap x0/x1) -> tt=16'h4444. perm=8'hE0 (duplicate) -> perm_err=1; sweep still completes with tt_valid.
4. EVAL_LAT=2 build, evaluator with 2-cycle registered output: case 1 again -> tt=16'h8000, tt_valid at 18 cycles, eval_x held in DRAIN.
5. Hold tt_ready=0 for 10 cycles in DONE -> tt/tt_valid stable, req_ready=0, req_valid pulses ignored. Raise tt_ready -> IDLE next cycle, req_ready=1.
6. Assert rst at SWEEP cycle 7 -> all outputs return to reset values asynchronously. A new request after release completes correctly with no stale bits in tt.
